// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Bubble is the canonical NOP (addi x0, x0, 0) shown to decode when nothing is valid.
package fetch_unit_pkg;

    localparam logic [31:0] Bubble = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
    } fetch_req_t;

    typedef struct packed {
        logic [31:0] data;
    } fetch_resp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_to_decode_t;

    localparam int unsigned FetchToDecodeW = $bits(fetch_to_decode_t);

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
// DEPTH need not be a power of two; pointers wrap explicitly.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: pipelined imem requests, in-order response tagging,
// instruction queue to decode, and redirect flush with stale-response dropping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1,
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            imem_req_valid,
    output logic [31:0]     imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_pc,
    output logic [31:0]     dec_inst,
    output logic [CntW-1:0] queue_count
);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [OutW-1:0]  outstanding_q, outstanding_d;
    logic [OutW-1:0]  drop_q, drop_d;

    fetch_req_t       req;
    fetch_resp_t      resp;
    fetch_to_decode_t q_push_data, q_head;

    logic             issue_ok, req_fire, resp_ok, resp_keep, deq;
    logic [31:0]      credit_used;
    logic [31:0]      tag_head;
    logic [OutW-1:0]  tag_count;
    logic             tag_full, tag_empty;
    logic [CntW-1:0]  q_count;
    logic             q_full, q_empty;

    assign req.addr  = fetch_pc_q;
    assign resp.data = imem_resp_data;

    // Every in-flight response must already own a free queue slot.
    assign credit_used = 32'(outstanding_q) + 32'(q_count);
    assign issue_ok    = !reset && !redirect_valid && (drop_q == '0) &&
                         (32'(outstanding_q) < MAX_OUTSTANDING) && (credit_used < QUEUE_DEPTH);

    assign req_fire  = issue_ok && imem_req_ready;
    assign resp_ok   = imem_resp_valid && (outstanding_q != '0);
    assign resp_keep = resp_ok && !redirect_valid && (drop_q == '0);

    assign dec_valid = !q_empty && !redirect_valid;
    assign deq       = dec_valid && dec_ready;

    assign q_push_data = '{pc: tag_head, inst: resp.data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_valid) begin
            // Nothing issues this cycle, so whatever is still in flight afterwards is stale.
            fetch_pc_d    = redirect_pc;
            outstanding_d = outstanding_q - OutW'(resp_ok);
            drop_d        = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = next_pc(fetch_pc_q);
            outstanding_d = outstanding_q + OutW'(req_fire) - OutW'(resp_ok);
            if (resp_ok && (drop_q != '0)) drop_d = drop_q - OutW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (resp_keep),
        .pop_data  (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_queue #(
        .WIDTH (FetchToDecodeW),
        .DEPTH (QUEUE_DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data (q_push_data),
        .pop       (deq),
        .pop_data  (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign imem_req_valid = issue_ok;
    assign imem_req_addr  = req.addr;
    assign dec_pc         = dec_valid ? q_head.pc : '0;
    assign dec_inst       = dec_valid ? q_head.inst : Bubble;
    assign queue_count    = q_count;

    resp_without_request: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (outstanding_q != '0));

    tag_no_overflow: assert property (@(posedge clk) disable iff (reset)
        req_fire |-> !tag_full);

    tag_present_for_resp: assert property (@(posedge clk) disable iff (reset)
        resp_keep |-> !tag_empty);

    queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
        resp_keep |-> (!q_full || deq));

    tags_track_live_requests: assert property (@(posedge clk) disable iff (reset)
        (drop_q == '0) |-> (tag_count == outstanding_q));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order variable-latency memory model plus a
// path-based reference (delivered pcs run consecutively from the last redirect target).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam int unsigned Qd      = 4;
    localparam int unsigned Mo      = 2;
    localparam int unsigned CntW    = $clog2(Qd) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            imem_req_valid;
    logic [31:0]     imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_pc;
    logic [31:0]     dec_inst;
    logic [CntW-1:0] queue_count;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC        (ResetPc),
        .QUEUE_DEPTH     (Qd),
        .MAX_OUTSTANDING (Mo)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_inst        (dec_inst),
        .queue_count     (queue_count)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model and reference state
    logic [31:0] pend_addr [$];
    int unsigned pend_due  [$];
    int unsigned cyc = 0, last_due = 0, inflight = 0, delivered = 0;
    logic [31:0] exp_pc = ResetPc, exp_req = ResetPc, mark_pc;
    bit          prev_redir = 0, mark_armed = 0;
    int unsigned lat_min = 1, lat_max = 1, rdy_pct = 100, dec_pct = 100, redir_pct = 0;

    task automatic arm_mark();
        mark_armed = 1;
        mark_pc    = 32'hDEAD_BEEF;
    endtask

    // Called on the negative edge: check outputs and account for this cycle's handshakes.
    task automatic observe();
        int unsigned due;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            inflight   = 0;
            exp_pc     = ResetPc;
            exp_req    = ResetPc;
            prev_redir = 0;
            return;
        end
        if (!dec_valid) begin
            check_eq("bubble_inst", dec_inst, Bubble);
            check_eq("bubble_pc", dec_pc, 0);
        end
        if (prev_redir) check_eq("dec_valid_after_redirect", dec_valid, 0);
        check_eq("req_addr", imem_req_addr, exp_req);
        check_eq("credit", (inflight + queue_count) <= Qd, 1);
        check_eq("inflight_max", inflight <= Mo, 1);
        if (imem_resp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            inflight--;
        end
        if (redirect_valid) begin
            check_eq("redirect_dec_valid", dec_valid, 0);
            check_eq("redirect_req_valid", imem_req_valid, 0);
            exp_pc     = redirect_pc;
            exp_req    = redirect_pc;
            prev_redir = 1;
        end else begin
            prev_redir = 0;
            if (dec_valid && dec_ready) begin
                check_eq("dec_pc", dec_pc, exp_pc);
                check_eq("dec_inst", dec_inst, inst_of(exp_pc));
                if (mark_armed) begin
                    mark_pc    = dec_pc;
                    mark_armed = 0;
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (imem_req_valid && imem_req_ready) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(due);
                inflight++;
                exp_req = exp_req + 32'd4;
            end
        end
    endtask

    task automatic set_inputs();
        cyc++;
        imem_resp_valid = (pend_due.size() != 0) && (pend_due[0] <= cyc);
        imem_resp_data  = imem_resp_valid ? inst_of(pend_addr[0]) : $urandom();
        imem_req_ready  = $urandom_range(99, 0) < rdy_pct;
        dec_ready       = $urandom_range(99, 0) < dec_pct;
        redirect_valid  = $urandom_range(99, 0) < redir_pct;
        redirect_pc     = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0
                                                      : ($urandom() & 32'hFFFF_FFFC);
    endtask

    task automatic run(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            observe();
            @(posedge clk);
            #1;
            set_inputs();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, imem_req_valid, 0);
        check_eq({tag, "_req_addr"}, imem_req_addr, ResetPc);
        check_eq({tag, "_dec_valid"}, dec_valid, 0);
        check_eq({tag, "_dec_pc"}, dec_pc, 0);
        check_eq({tag, "_dec_inst"}, dec_inst, Bubble);
        check_eq({tag, "_queue_count"}, queue_count, 0);
    endtask

    initial begin
        int unsigned d0;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        dec_ready       = 1'b0;

        // Reset values, then sustained 1-cycle-memory streaming
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        observe();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_inputs();
        d0 = delivered;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check_eq("first_req_valid", imem_req_valid, 1);
                check_eq("first_req_addr", imem_req_addr, ResetPc);
            end
            if (k == 1) check_eq("no_bypass_dec_valid", dec_valid, 0);
            if (k == 2) check_eq("first_dec_valid", dec_valid, 1);
            observe();
            @(posedge clk);
            #1;
            set_inputs();
        end
        check_eq("throughput", delivered - d0, 18);

        // Decode stall saturates the queue and stops fetch
        dec_pct = 0;
        do_reset();
        run(10);
        check_eq("stall_queue_count", queue_count, Qd);
        check_eq("stall_req_valid", imem_req_valid, 0);
        check_eq("stall_inflight", inflight, 0);
        check_eq("stall_fetch_pc", imem_req_addr, 32'h10);
        dec_pct   = 100;
        dec_ready = 1'b1;
        d0        = delivered;
        arm_mark();
        run(6);
        check_eq("stall_drain_first", mark_pc, ResetPc);
        check_eq("stall_drain_count", (delivered - d0) >= 4, 1);

        // 3-cycle memory latency
        lat_min = 3;
        lat_max = 3;
        d0      = delivered;
        run(40);
        check_eq("lat3_progress", (delivered - d0) >= 10, 1);

        // Redirect with two requests outstanding
        for (int i = 0; i < 20 && inflight != 2; i++) run(1);
        check_eq("wait_two_outstanding", inflight, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        arm_mark();
        run(16);
        check_eq("redirect_first_pc", mark_pc, 32'h200);

        // Redirect during response+dequeue, then back-to-back redirects
        lat_min = 1;
        lat_max = 1;
        run(10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        run(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        arm_mark();
        run(12);
        check_eq("double_redirect_first_pc", mark_pc, 32'h300);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        arm_mark();
        run(12);
        check_eq("wrap_first_pc", mark_pc, 32'hFFFF_FFF8);

        // Random traffic
        lat_min   = 1;
        lat_max   = 4;
        rdy_pct   = 70;
        dec_pct   = 70;
        redir_pct = 3;
        run(2000);

        // Asynchronous reset in the middle of a burst
        lat_max   = 1;
        rdy_pct   = 100;
        dec_pct   = 100;
        redir_pct = 0;
        run(10);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        run(2);
        reset = 1'b0;
        arm_mark();
        run(10);
        check_eq("post_reset_first_pc", mark_pc, ResetPc);

        check_eq("liveness", delivered > 200, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
